// File: rtl/rl_ram_nr1w.sv
// rl_ram_nr1w: multi-read, single-write synchronous RAM with byte enables.
// Reads that hit the same-cycle write address see the write merged per byte.
// Read latency is 1 cycle (OUTREG=0) or 2 cycles (OUTREG=1).
module rl_ram_nr1w #(
    parameter int unsigned ABITS  = 10,
    parameter int unsigned DBITS  = 32,
    parameter int unsigned RPORTS = 2,
    parameter int unsigned OUTREG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ABITS-1:0]          waddr,
    input  logic [DBITS-1:0]          din,
    input  logic                      we,
    input  logic [(DBITS+7)/8-1:0]    be,
    input  logic [RPORTS-1:0]         re,
    input  logic [RPORTS*ABITS-1:0]   raddr,
    output logic [RPORTS*DBITS-1:0]   dout,
    output logic [RPORTS-1:0]         dvalid
);

    localparam int unsigned DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem    [DEPTH];
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] merged [RPORTS];
    logic [DBITS-1:0] s1_d   [RPORTS];
    logic [RPORTS-1:0] s1_v;
    logic [DBITS-1:0] out_d  [RPORTS];
    logic [RPORTS-1:0] out_v;

    // Expand byte enables to a per-bit mask; the top enable also covers a partial byte.
    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < DBITS; b++) begin
            wmask[b] = be[b / 8];
        end
    end

    // Byte-enabled write; suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int unsigned b = 0; b < DBITS; b++) begin
                if (wmask[b]) begin
                    mem[waddr][b] <= din[b];
                end
            end
        end
    end

    // Per-port write-first bypass: on address match, enabled bytes come from din.
    always_comb begin
        for (int unsigned i = 0; i < RPORTS; i++) begin
            merged[i] = mem[raddr[i*ABITS +: ABITS]];
            if (we && (waddr == raddr[i*ABITS +: ABITS])) begin
                merged[i] = (merged[i] & ~wmask) | (din & wmask);
            end
        end
    end

    // Stage 1: capture read data on enable, hold otherwise; valid follows re.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= '0;
            for (int unsigned i = 0; i < RPORTS; i++) begin
                s1_d[i] <= '0;
            end
        end else begin
            s1_v <= re;
            for (int unsigned i = 0; i < RPORTS; i++) begin
                if (re[i]) begin
                    s1_d[i] <= merged[i];
                end
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            logic [DBITS-1:0]  s2_d [RPORTS];
            logic [RPORTS-1:0] s2_v;

            // Stage 2: copy stage 1 only when it carries a valid read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_v <= '0;
                    for (int unsigned i = 0; i < RPORTS; i++) begin
                        s2_d[i] <= '0;
                    end
                end else begin
                    s2_v <= s1_v;
                    for (int unsigned i = 0; i < RPORTS; i++) begin
                        if (s1_v[i]) begin
                            s2_d[i] <= s1_d[i];
                        end
                    end
                end
            end

            // Output taken from stage 2.
            always_comb begin
                out_v = s2_v;
                for (int unsigned i = 0; i < RPORTS; i++) begin
                    out_d[i] = s2_d[i];
                end
            end
        end else begin : g_noreg
            // Output taken directly from stage 1.
            always_comb begin
                out_v = s1_v;
                for (int unsigned i = 0; i < RPORTS; i++) begin
                    out_d[i] = s1_d[i];
                end
            end
        end
    endgenerate

    // Pack per-port outputs onto the flat buses.
    always_comb begin
        dout   = '0;
        dvalid = out_v;
        for (int unsigned i = 0; i < RPORTS; i++) begin
            dout[i*DBITS +: DBITS] = out_d[i];
        end
    end

endmodule

// File: tb/tb_rl_ram_nr1w.sv
// tb_rl_ram_nr1w: drives one latency-1 and one latency-2 instance with identical
// stimulus and compares both against a byte-level memory model with delayed delivery.
module tb_rl_ram_nr1w;

    localparam int AB = 5;
    localparam int DB = 32;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [AB-1:0]   waddr;
    logic [DB-1:0]   din;
    logic            we;
    logic [3:0]      be;
    logic [NP-1:0]   re;
    logic [NP*AB-1:0] raddr;
    logic [NP*DB-1:0] dout_a, dout_b;
    logic [NP-1:0]   dv_a, dv_b;

    int checks = 0;
    int errors = 0;

    rl_ram_nr1w #(.ABITS(AB), .DBITS(DB), .RPORTS(NP), .OUTREG(0)) u_a (
        .clk(clk), .rst(rst), .waddr(waddr), .din(din), .we(we), .be(be),
        .re(re), .raddr(raddr), .dout(dout_a), .dvalid(dv_a));

    rl_ram_nr1w #(.ABITS(AB), .DBITS(DB), .RPORTS(NP), .OUTREG(1)) u_b (
        .clk(clk), .rst(rst), .waddr(waddr), .din(din), .we(we), .be(be),
        .re(re), .raddr(raddr), .dout(dout_b), .dvalid(dv_b));

    always #5 clk = ~clk;

    // Reference model: memory words plus per-byte "has been written" flags.
    logic [31:0] mm [32];
    logic [3:0]  mk [32];
    // Issue history per port: slot 0 = read issued at the last edge, slot 1 = the one before.
    logic        hv [NP][2];
    logic [31:0] hd [NP][2];
    logic        hk [NP][2];
    // Expected held outputs per latency (index 0 -> L=1, 1 -> L=2).
    logic        ev [2][NP];
    logic [31:0] ed [2][NP];
    logic        ek [2][NP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; be = 4'h0; re = '0;
    endtask

    task automatic tick();
        logic [31:0] nd [NP];
        logic        nv [NP];
        logic        nk [NP];
        for (int p = 0; p < NP; p++) begin
            logic [AB-1:0] a;
            a = raddr[p*AB +: AB];
            nv[p] = !rst && re[p];
            nk[p] = 1'b1;
            nd[p] = '0;
            for (int k = 0; k < 4; k++) begin
                if (we && waddr == a && be[k]) begin
                    nd[p][8*k +: 8] = din[8*k +: 8];
                end else begin
                    nd[p][8*k +: 8] = mm[a][8*k +: 8];
                    if (!mk[a][k]) nk[p] = 1'b0;
                end
            end
        end
        if (!rst && we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mm[waddr][8*k +: 8] = din[8*k +: 8];
                    mk[waddr][k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                hv[p][0] = 1'b0; hv[p][1] = 1'b0;
                for (int l = 0; l < 2; l++) begin
                    ev[l][p] = 1'b0; ed[l][p] = '0; ek[l][p] = 1'b1;
                end
            end else begin
                hv[p][1] = hv[p][0]; hd[p][1] = hd[p][0]; hk[p][1] = hk[p][0];
                hv[p][0] = nv[p];    hd[p][0] = nd[p];    hk[p][0] = nk[p];
                for (int l = 0; l < 2; l++) begin
                    ev[l][p] = hv[p][l];
                    if (hv[p][l]) begin
                        ed[l][p] = hd[p][l];
                        ek[l][p] = hk[p][l];
                    end
                end
            end
            chk($sformatf("dvalid_L1_p%0d", p), {31'b0, dv_a[p]}, {31'b0, ev[0][p]});
            chk($sformatf("dvalid_L2_p%0d", p), {31'b0, dv_b[p]}, {31'b0, ev[1][p]});
            if (ek[0][p]) chk($sformatf("dout_L1_p%0d", p), dout_a[p*DB +: DB], ed[0][p]);
            if (ek[1][p]) chk($sformatf("dout_L2_p%0d", p), dout_b[p*DB +: DB], ed[1][p]);
        end
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [31:0] d, input logic [3:0] b);
        idle();
        we = 1'b1; waddr = a; din = d; be = b;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mm[i] = '0; mk[i] = 4'h0;
        end
        for (int p = 0; p < NP; p++) begin
            hv[p][0] = 1'b0; hv[p][1] = 1'b0;
            hd[p][0] = '0;   hd[p][1] = '0;
            hk[p][0] = 1'b1; hk[p][1] = 1'b1;
            for (int l = 0; l < 2; l++) begin
                ev[l][p] = 1'b0; ed[l][p] = '0; ek[l][p] = 1'b1;
            end
        end
        rst = 1'b1; waddr = '0; din = '0; raddr = '0;
        idle();
        tick();
        tick();

        // Reset with reads and a write requested: nothing happens.
        we = 1'b1; waddr = 5'd9; din = 32'hFFFF_FFFF; be = 4'hF;
        re = '1; raddr = {5'd9, 5'd9};
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_dout_L1", dout_a[31:0], 32'h0);
            chk("rst_dvalid_L2", {30'b0, dv_b}, 32'h0);
        end
        rst = 1'b0;
        idle();
        tick();
        wr(5'd9, 32'h0, 4'hF);
        re = 2'b01; raddr = {5'd0, 5'd9};
        tick();
        idle();
        tick();
        chk("rst_nowrite_L2", dout_b[31:0], 32'h0);

        // Basic write then read on port 0.
        wr(5'd5, 32'hDEAD_BEEF, 4'hF);
        idle();
        re = 2'b01; raddr = {5'd0, 5'd5};
        tick();
        idle();
        chk("basic_L1_data", dout_a[31:0], 32'hDEAD_BEEF);
        chk("basic_L1_valid", {31'b0, dv_a[0]}, 32'h1);
        tick();
        chk("basic_L1_drop", {31'b0, dv_a[0]}, 32'h0);
        chk("basic_L2_data", dout_b[31:0], 32'hDEAD_BEEF);
        tick();
        chk("basic_L2_drop", {31'b0, dv_b[0]}, 32'h0);

        // Byte-merge collision on both ports.
        wr(5'd7, 32'h1122_3344, 4'hF);
        we = 1'b1; waddr = 5'd7; din = 32'hAABB_CCDD; be = 4'b0101;
        re = 2'b11; raddr = {5'd7, 5'd7};
        tick();
        idle();
        chk("merge_L1_p0", dout_a[31:0], 32'h11BB_33DD);
        chk("merge_L1_p1", dout_a[63:32], 32'h11BB_33DD);
        tick();
        chk("merge_L2_p1", dout_b[63:32], 32'h11BB_33DD);
        re = 2'b10; raddr = {5'd7, 5'd0};
        tick();
        idle();
        chk("merge_stored", dout_a[63:32], 32'h11BB_33DD);

        // Port independence with an unrelated write.
        wr(5'd1, 32'h1, 4'hF);
        wr(5'd2, 32'h2, 4'hF);
        we = 1'b1; waddr = 5'd3; din = 32'h5555_5555; be = 4'hF;
        re = 2'b11; raddr = {5'd2, 5'd1};
        tick();
        idle();
        chk("indep_p0", dout_a[31:0], 32'h1);
        chk("indep_p1", dout_a[63:32], 32'h2);
        tick();

        // Streaming reads of 0..15 then hold.
        for (int a = 0; a < 16; a++) wr(a[4:0], $urandom, 4'hF);
        idle();
        for (int a = 0; a < 16; a++) begin
            re = 2'b01; raddr = {5'd0, a[4:0]};
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) tick();
        chk("hold_L1", dout_a[31:0], mm[15]);
        chk("hold_L2", dout_b[31:0], mm[15]);

        // Back-to-back writes with a read colliding with the second.
        wr(5'd20, 32'h0102_0304, 4'hF);
        we = 1'b1; waddr = 5'd20; din = 32'hA0B0_C0D0; be = 4'b0011;
        re = 2'b01; raddr = {5'd0, 5'd20};
        tick();
        idle();
        chk("b2b_L1", dout_a[31:0], 32'h0102_C0D0);
        tick();

        // Reset arriving while a read is in flight.
        re = 2'b01; raddr = {5'd0, 5'd5};
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_L2_valid", {31'b0, dv_b[0]}, 32'h0);
        chk("midrst_L2_data", dout_b[31:0], 32'h0);
        tick();
        chk("midrst_after", dout_b[31:0], 32'h0);

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            we    = $urandom_range(0, 1);
            waddr = 5'(16 + $urandom_range(0, 3));
            din   = $urandom;
            be    = 4'($urandom);
            re    = 2'($urandom);
            raddr = {5'(16 + $urandom_range(0, 3)), 5'(16 + $urandom_range(0, 3))};
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
